// File: rtl/InterruptArbiterPkg.sv
// Shared constants, types and helpers for the single-target interrupt claim arbiter.
package InterruptArbiterPkg;

   localparam int NUM_INT_PORTS = 16;
   localparam int PRIO_W        = 2;
   localparam int ID_W          = $clog2(NUM_INT_PORTS);

   typedef logic [PRIO_W-1:0] prio_t;
   typedef logic [ID_W-1:0]   int_id_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OFFER,
      ARB_SERVICE
   } arb_state_e;

   function automatic logic [NUM_INT_PORTS-1:0] id_onehot(input int_id_t id);
      logic [NUM_INT_PORTS-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/int_prio_rr_select.sv
// Combinational winner select: highest priority among eligible sources,
// ties broken by scanning upward from the slot after the last claimed id.
module int_prio_rr_select
   import InterruptArbiterPkg::*;
(
   input  logic [NUM_INT_PORTS-1:0]        eligible,
   input  logic [NUM_INT_PORTS*PRIO_W-1:0] prio,
   input  int_id_t                         rr_ptr,
   output logic                            valid,
   output int_id_t                         winner
);

   prio_t                    max_prio;
   logic [NUM_INT_PORTS-1:0] top_mask;
   logic [NUM_INT_PORTS-1:0] rotated;
   int_id_t                  start;
   int_id_t                  offset;

   always_comb begin
      max_prio = '0;
      for (int i = 0; i < NUM_INT_PORTS; i++) begin
         if (eligible[i] && (prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
            max_prio = prio[i*PRIO_W +: PRIO_W];
         end
      end

      for (int i = 0; i < NUM_INT_PORTS; i++) begin
         top_mask[i] = eligible[i] && (prio[i*PRIO_W +: PRIO_W] == max_prio);
      end

      // Rotate so the round-robin start slot lands at bit 0, then take the lowest set bit.
      start = int_id_t'((int'(rr_ptr) + 1) % NUM_INT_PORTS);
      for (int j = 0; j < NUM_INT_PORTS; j++) begin
         rotated[j] = top_mask[int_id_t'((j + int'(start)) % NUM_INT_PORTS)];
      end

      offset = '0;
      for (int j = NUM_INT_PORTS - 1; j >= 0; j--) begin
         if (rotated[j]) begin
            offset = int_id_t'(j);
         end
      end

      valid  = |top_mask;
      winner = int_id_t'((int'(offset) + int'(start)) % NUM_INT_PORTS);
   end

endmodule

// File: rtl/int_claim_arbiter.sv
// Single-target interrupt arbiter: latches requests, offers the best source,
// and tracks one claimed source until software completes it.
module int_claim_arbiter
   import InterruptArbiterPkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_INT_PORTS-1:0]        int_req_i,
   input  logic [NUM_INT_PORTS-1:0]        int_en_i,
   input  logic [NUM_INT_PORTS*PRIO_W-1:0] int_prio_i,
   output logic                            irq_o,
   output int_id_t                         irq_id_o,
   input  logic                            claim_i,
   input  logic                            complete_i,
   input  int_id_t                         complete_id_i,
   output logic                            busy_o,
   output logic                            err_o
);

   arb_state_e               state, state_n;
   logic [NUM_INT_PORTS-1:0] pending, pending_n;
   logic [NUM_INT_PORTS-1:0] in_service, in_service_n;
   logic [NUM_INT_PORTS-1:0] prio_nz;
   logic [NUM_INT_PORTS-1:0] eligible;
   int_id_t                  rr_ptr, rr_ptr_n;
   int_id_t                  svc_id, svc_id_n;
   int_id_t                  irq_id_n;
   logic                     err_n;
   logic                     sel_valid;
   int_id_t                  sel_id;

   for (genvar g = 0; g < NUM_INT_PORTS; g++) begin : g_prio_nz
      assign prio_nz[g] = |int_prio_i[g*PRIO_W +: PRIO_W];
   end

   assign eligible = pending & int_en_i & prio_nz & ~in_service;

   int_prio_rr_select u_select (
      .eligible (eligible),
      .prio     (int_prio_i),
      .rr_ptr   (rr_ptr),
      .valid    (sel_valid),
      .winner   (sel_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         pending    <= '0;
         in_service <= '0;
         rr_ptr     <= '0;
         svc_id     <= '0;
         irq_id_o   <= '0;
         err_o      <= 1'b0;
      end else begin
         state      <= state_n;
         pending    <= pending_n;
         in_service <= in_service_n;
         rr_ptr     <= rr_ptr_n;
         svc_id     <= svc_id_n;
         irq_id_o   <= irq_id_n;
         err_o      <= err_n;
      end
   end

   // A claim clears the claimed pending bit and wins over a request arriving in the same cycle.
   always_comb begin
      state_n      = state;
      pending_n    = pending | int_req_i;
      in_service_n = in_service;
      rr_ptr_n     = rr_ptr;
      svc_id_n     = svc_id;
      irq_id_n     = irq_id_o;
      err_n        = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (sel_valid) begin
               irq_id_n = sel_id;
               state_n  = ARB_OFFER;
            end
            if (claim_i || complete_i) begin
               err_n = 1'b1;
            end
         end
         ARB_OFFER: begin
            if (claim_i) begin
               pending_n    = (pending | int_req_i) & ~id_onehot(irq_id_o);
               in_service_n = in_service | id_onehot(irq_id_o);
               rr_ptr_n     = irq_id_o;
               svc_id_n     = irq_id_o;
               state_n      = ARB_SERVICE;
            end else if (sel_valid) begin
               irq_id_n = sel_id;
            end else begin
               state_n = ARB_IDLE;
            end
            if (complete_i) begin
               err_n = 1'b1;
            end
         end
         ARB_SERVICE: begin
            if (claim_i) begin
               err_n = 1'b1;
            end
            if (complete_i) begin
               if (complete_id_i == svc_id) begin
                  in_service_n = in_service & ~id_onehot(svc_id);
                  state_n      = ARB_IDLE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = ARB_IDLE;
         end
      endcase
   end

   assign irq_o  = (state == ARB_OFFER);
   assign busy_o = (state == ARB_SERVICE);

endmodule
